conv_sched: RTL

CONV_SCHED -- requirements
Module: conv_sched

---
 rtl/conv_sched_pkg.sv | 28 ++
 rtl/conv_pos_counter.sv | 46 ++++
 rtl/conv_sched.sv | 123 ++++++++++++
 3 files changed

// File: rtl/conv_sched_pkg.sv
// Shared definitions for the 3x3 convolution scheduler: FSM state encoding,
// kernel geometry and field widths used by conv_sched and conv_pos_counter.
package conv_sched_pkg;

  // Rows (and columns) of the convolution kernel; one MAC state per row.
  localparam int MAC_ROWS = 3;

  // Width of the i/j position counters and of the result address.
  localparam int POS_W  = 5;
  localparam int ADDR_W = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    LOAD  = 3'd2,
    MAC0  = 3'd3,
    MAC1  = 3'd4,
    MAC2  = 3'd5,
    STORE = 3'd6,
    FIN   = 3'd7
  } state_t;

  // True for the states that belong to an active scan (busy is high).
  function automatic logic in_scan(input state_t s);
    return (s != IDLE) && (s != FIN);
  endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Output-position counter for the convolution scan. Walks j across the
// (W-2)-wide output row, wraps to the next row i, and flags the final
// position of the (H-2)x(W-2) output image.
module conv_pos_counter
  import conv_sched_pkg::*;
#(
  parameter int H = 28,
  parameter int W = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step,
  output logic [POS_W-1:0] i,
  output logic [POS_W-1:0] j,
  output logic             last
);

  // Last valid output row/column: a 3x3 kernel leaves (dim - MAC_ROWS + 1) outputs.
  localparam logic [POS_W-1:0] I_LAST = POS_W'(H - MAC_ROWS);
  localparam logic [POS_W-1:0] J_LAST = POS_W'(W - MAC_ROWS);
  localparam logic [POS_W-1:0] ONE    = POS_W'(1);

  // Position register: clear wins over step; step advances j with row wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state is written with <= so every flop samples the
      // pre-edge values of its inputs regardless of statement order.
      i <= '0;
      j <= '0;
    end else if (clear) begin
      i <= '0;
      j <= '0;
    end else if (step) begin
      if (j == J_LAST) begin
        j <= '0;
        i <= i + ONE;
      end else begin
        j <= j + ONE;
      end
    end
  end

  assign last = (i == I_LAST) && (j == J_LAST);

endmodule

// File: rtl/conv_sched.sv
// Control FSM for a 3x3 convolution engine. For every output position it
// issues addr_en, load, three acc_en cycles (kernel rows 0..2 via mux_sel)
// and a store that may be back-pressured by store_ready. A one-cycle done
// pulse follows the last accepted store.
// Optional feature: define CONV_SCHED_ABORT_EN to add an abort input that
// drops any scan in progress back to IDLE without a done pulse.
module conv_sched
  import conv_sched_pkg::*;
#(
  parameter int H = 28,
  parameter int W = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              store_ready,
`ifdef CONV_SCHED_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic              addr_en,
  output logic              load,
  output logic [1:0]        mux_sel,
  output logic              acc_en,
  output logic              store,
  output logic [POS_W-1:0]  i,
  output logic [POS_W-1:0]  j,
  output logic [ADDR_W-1:0] out_addr
);

  // Output row pitch: one result per valid kernel placement across a row.
  localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(W - MAC_ROWS + 1);

  state_t state_q;
  state_t state_d;

  logic abort_req;
  logic scanning;
  logic accepted;
  logic start_acc;
  logic pos_clear;
  logic pos_step;
  logic pos_last;

`ifdef CONV_SCHED_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign scanning  = in_scan(state_q);
  assign accepted  = (state_q == STORE) && store_ready;
  assign start_acc = (state_q == IDLE) && start;

  // An abort clears the position and suppresses the step of a store that
  // would otherwise have been accepted on the same cycle.
  assign pos_clear = start_acc || (abort_req && scanning);
  assign pos_step  = accepted && !abort_req;

  conv_pos_counter #(
    .H (H),
    .W (W)
  ) u_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (pos_clear),
    .step  (pos_step),
    .i     (i),
    .j     (j),
    .last  (pos_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: fixed per-position sequence, STORE waits on store_ready.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADDR;
      ADDR:    state_d = LOAD;
      LOAD:    state_d = MAC0;
      MAC0:    state_d = MAC1;
      MAC1:    state_d = MAC2;
      MAC2:    state_d = STORE;
      STORE:   if (store_ready) state_d = pos_last ? FIN : ADDR;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_req && scanning) state_d = IDLE;
  end

  // Output decode: one strobe per state, mux_sel selects the kernel row.
  always_comb begin
    busy    = scanning;
    done    = 1'b0;
    addr_en = 1'b0;
    load    = 1'b0;
    acc_en  = 1'b0;
    store   = 1'b0;
    mux_sel = 2'd0;
    case (state_q)
      ADDR:  addr_en = 1'b1;
      LOAD:  load    = 1'b1;
      MAC0:  begin acc_en = 1'b1; mux_sel = 2'd0; end
      MAC1:  begin acc_en = 1'b1; mux_sel = 2'd1; end
      MAC2:  begin acc_en = 1'b1; mux_sel = 2'd2; end
      STORE: store   = 1'b1;
      FIN:   done    = 1'b1;
      default: ;
    endcase
  end

  // Result address from the registered position, truncated to ADDR_W bits.
  assign out_addr = (ADDR_W'(i) * ROW_PITCH) + ADDR_W'(j);

endmodule
